// File: rtl/limb_sequencer.sv
// Multi-cycle control FSM of the limb 8-bit CPU: owns PC/IR, sequences fetch, decode, execute, memory and writeback.
// Optional build macro LIMB_SEQ_TRAP_EN: undefined opcodes halt the core from DECODE instead of retiring.
module limb_sequencer #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter int         MEM_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic [7:0]  rom_addr,
    input  logic [31:0] rom_data,
    output logic [2:0]  rf_src_a,
    output logic [2:0]  rf_src_b,
    output logic [2:0]  rf_dst,
    output logic        rf_we,
    output logic [7:0]  rf_wdata,
    input  logic [7:0]  rf_out_a,
    input  logic [7:0]  rf_out_b,
    output logic [3:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [7:0]  alu_out,
    input  logic        cond_true,
    output logic [7:0]  ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    input  logic [7:0]  ram_rdata,
    output logic        halted,
    output logic        retire
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
    } state_t;

    localparam logic [1:0] CLS_ALU  = 2'b00;
    localparam logic [1:0] CLS_COND = 2'b01;
    localparam logic [1:0] CLS_MEM  = 2'b10;
    localparam logic [1:0] CLS_SYS  = 2'b11;
    localparam logic [1:0] LAST_WAIT = 2'(MEM_WAIT - 1);

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [7:0]  alu_a_q, alu_a_d;
    logic [7:0]  alu_b_q, alu_b_d;
    logic [3:0]  alu_op_q, alu_op_d;
    logic [7:0]  ram_addr_q, ram_addr_d;
    logic [7:0]  ram_wdata_q, ram_wdata_d;
    logic [7:0]  res_q, res_d;
    logic [1:0]  wait_q, wait_d;

    logic       imm_a, imm_b;
    logic [1:0] cls;
    logic [3:0] op;
    logic [7:0] arg_a, arg_b, result;
    logic [7:0] opa_val, opb_val;
    logic       trap_op;

    assign imm_a   = ir_q[7];
    assign imm_b   = ir_q[6];
    assign cls     = ir_q[5:4];
    assign op      = ir_q[3:0];
    assign arg_a   = ir_q[15:8];
    assign arg_b   = ir_q[23:16];
    assign result  = ir_q[31:24];
    assign opa_val = imm_a ? arg_a : rf_out_a;
    assign opb_val = imm_b ? arg_b : rf_out_b;

`ifdef LIMB_SEQ_TRAP_EN
    assign trap_op = (((cls == CLS_SYS) || (cls == CLS_MEM)) && (op >= 4'd2)) ||
                     (((cls == CLS_ALU) || (cls == CLS_COND)) && op[3]);
`else
    assign trap_op = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= 32'h0;
            alu_a_q     <= 8'h0;
            alu_b_q     <= 8'h0;
            alu_op_q    <= 4'h0;
            ram_addr_q  <= 8'h0;
            ram_wdata_q <= 8'h0;
            res_q       <= 8'h0;
            wait_q      <= 2'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            res_q       <= res_d;
            wait_q      <= wait_d;
        end
    end

    // Operands are latched straight into the ALU/RAM-facing registers, so those
    // outputs naturally hold their last value outside EXECUTE/MEM.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        res_d       = res_q;
        wait_d      = wait_q;
        case (state_q)
            S_FETCH: begin
                if (run) begin
                    ir_d    = rom_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (trap_op) begin
                    state_d = S_HALT;
                end else begin
                    case (cls)
                        CLS_ALU, CLS_COND: begin
                            alu_a_d  = opa_val;
                            alu_b_d  = opb_val;
                            alu_op_d = op;
                            state_d  = S_EXECUTE;
                        end
                        CLS_MEM: begin
                            ram_addr_d  = opa_val;
                            ram_wdata_d = opb_val;
                            wait_d      = 2'd0;
                            state_d     = S_MEM;
                        end
                        default: begin
                            if (op == 4'd1) begin
                                state_d = S_HALT;
                            end else begin
                                pc_d    = pc_q + 8'd1;
                                state_d = S_FETCH;
                            end
                        end
                    endcase
                end
            end
            S_EXECUTE: begin
                if (cls == CLS_ALU) begin
                    res_d   = alu_out;
                    state_d = S_WRITEBACK;
                end else begin
                    pc_d    = cond_true ? result : pc_q + 8'd1;
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                if (op == 4'd0) begin
                    if (wait_q == LAST_WAIT) begin
                        res_d   = ram_rdata;
                        state_d = S_WRITEBACK;
                    end else begin
                        wait_d = wait_q + 2'd1;
                    end
                end else begin
                    pc_d    = pc_q + 8'd1;
                    state_d = S_FETCH;
                end
            end
            S_WRITEBACK: begin
                pc_d    = pc_q + 8'd1;
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    // Strobes depend only on registered state so reset drops them without a clock.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_DECODE:    retire = (cls == CLS_SYS) && !trap_op;
            S_EXECUTE:   retire = (cls == CLS_COND);
            S_MEM:       retire = (op != 4'd0);
            S_WRITEBACK: retire = 1'b1;
            default:     retire = 1'b0;
        endcase
    end

    assign rom_addr  = pc_q;
    assign rf_src_a  = arg_a[2:0];
    assign rf_src_b  = arg_b[2:0];
    assign rf_dst    = result[2:0];
    assign rf_wdata  = res_q;
    assign rf_we     = (state_q == S_WRITEBACK);
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = (state_q == S_MEM) && (op == 4'd1);
    assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_limb_sequencer.sv
// Self-checking bench for limb_sequencer: directed vector table, hand-written corner sequences and
// a random program checked against an instruction-level model of the limb ISA.
module tb_limb_sequencer;

    localparam int MW = 3;

    logic        clk;
    logic        reset;
    logic        run;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic [2:0]  rf_src_a, rf_src_b, rf_dst;
    logic        rf_we;
    logic [7:0]  rf_wdata, rf_out_a, rf_out_b;
    logic [3:0]  alu_op;
    logic [7:0]  alu_a, alu_b, alu_out;
    logic        cond_true;
    logic [7:0]  ram_addr, ram_wdata, ram_rdata;
    logic        ram_we, halted, retire;

    limb_sequencer #(.RESET_PC(8'h00), .MEM_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .run(run),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .rf_src_a(rf_src_a), .rf_src_b(rf_src_b), .rf_dst(rf_dst),
        .rf_we(rf_we), .rf_wdata(rf_wdata),
        .rf_out_a(rf_out_a), .rf_out_b(rf_out_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .cond_true(cond_true),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .halted(halted), .retire(retire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- environment: ROM, register file, ALU, condition unit, RAM
    logic [31:0] rom [256];
    logic [7:0]  regs [8];
    logic [7:0]  ram [256];
    logic        env_init;
    logic        cond_ovr_en, cond_ovr_val;

    function automatic logic [7:0] reg_init(input int i);
        return 8'(i * 17 + 3);
    endfunction

    function automatic logic [7:0] ram_init(input int i);
        return 8'(i) ^ 8'h4A;
    endfunction

    function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ~a;
            4'd6: return a << 1;
            4'd7: return a >> 1;
            default: return a + b + {4'h0, op};
        endcase
    endfunction

    function automatic logic cond_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic c;
        case (op[1:0])
            2'd0: c = (a == b);
            2'd1: c = (a != b);
            2'd2: c = (a < b);
            default: c = (a >= b);
        endcase
        return c ^ op[2];
    endfunction

    assign rom_data  = rom[rom_addr];
    assign rf_out_a  = regs[rf_src_a];
    assign rf_out_b  = regs[rf_src_b];
    assign alu_out   = alu_fn(alu_op, alu_a, alu_b);
    assign cond_true = cond_ovr_en ? cond_ovr_val : cond_fn(alu_op, alu_a, alu_b);
    assign ram_rdata = ram[ram_addr];

    always @(posedge clk) begin
        if (env_init) begin
            for (int i = 0; i < 8; i++) regs[i] <= reg_init(i);
            for (int i = 0; i < 256; i++) ram[i] <= ram_init(i);
        end else begin
            if (rf_we) regs[rf_dst] <= rf_wdata;
            if (ram_we) ram[ram_addr] <= ram_wdata;
        end
    end

    // ---------------- checking
    int vec_cnt = 0;
    int miss_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        env_init = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        env_init = 1'b0;
        reset    = 1'b1;
    endtask

    // observed results of one instruction
    int         act_lat, act_nrf, act_nram;
    logic [2:0] act_dst;
    logic [7:0] act_wd, act_ra, act_rd;
    logic       act_halt;

    // Called at the falling edge of a FETCH cycle; returns at the falling edge after completion.
    task automatic run_instr();
        bit done;
        done = 0;
        act_lat = 0; act_nrf = 0; act_nram = 0;
        act_dst = 3'd0; act_wd = 8'h0; act_ra = 8'h0; act_rd = 8'h0;
        for (int c = 0; c < 40 && !done; c++) begin
            act_lat++;
            if (rf_we) begin act_nrf++; act_dst = rf_dst; act_wd = rf_wdata; end
            if (ram_we) begin act_nram++; act_ra = ram_addr; act_rd = ram_wdata; end
            if (retire || halted) done = 1;
            @(negedge clk);
        end
        chk("instr_complete", int'(done), 1);
        act_halt = halted;
    endtask

    // ---------------- instruction-level reference model
    logic [7:0] m_regs [8];
    logic [7:0] m_ram [256];
    int         exp_lat, exp_nrf, exp_nram;
    logic [2:0] exp_dst;
    logic [7:0] exp_wd, exp_ra, exp_rd, exp_npc;
    logic       exp_halt;

    task automatic model_step(input logic [7:0] pc);
        logic [31:0] w;
        logic [3:0]  op;
        logic [7:0]  a, b;
        bit          illegal;
        w  = rom[pc];
        op = w[3:0];
        a  = w[7] ? w[15:8]  : m_regs[w[10:8]];
        b  = w[6] ? w[23:16] : m_regs[w[18:16]];
        exp_nrf = 0; exp_nram = 0; exp_halt = 0;
        exp_dst = w[26:24]; exp_wd = 8'h0; exp_ra = 8'h0; exp_rd = 8'h0;
        exp_npc = pc + 8'd1;
        illegal = 0;
`ifdef LIMB_SEQ_TRAP_EN
        illegal = (w[5] && op >= 4'd2) || (!w[5] && op >= 4'd8);
`endif
        if (illegal) begin
            exp_lat = 3; exp_npc = pc; exp_halt = 1;
        end else begin
            case (w[5:4])
                2'b00: begin
                    exp_wd = alu_fn(op, a, b);
                    m_regs[exp_dst] = exp_wd;
                    exp_nrf = 1; exp_lat = 4;
                end
                2'b01: begin
                    exp_lat = 3;
                    if (cond_ovr_en ? cond_ovr_val : cond_fn(op, a, b)) exp_npc = w[31:24];
                end
                2'b10: begin
                    exp_lat = 3;
                    if (op == 4'd0) begin
                        exp_wd = m_ram[a];
                        m_regs[exp_dst] = exp_wd;
                        exp_nrf = 1; exp_lat = 3 + MW;
                    end else if (op == 4'd1) begin
                        m_ram[a] = b;
                        exp_nram = 1; exp_ra = a; exp_rd = b;
                    end
                end
                default: begin
                    exp_lat = 2;
                    if (op == 4'd1) begin exp_halt = 1; exp_npc = pc; end
                end
            endcase
        end
    endtask

    // ---------------- directed vector table
    typedef struct {
        logic [31:0] word;
        logic        cond_v;
        int          lat;
        logic [7:0]  npc;
        int          nrf;
        logic [2:0]  dst;
        logic [7:0]  wd;
        int          nram;
        logic [7:0]  ra;
        logic [7:0]  rd;
    } vec_t;

    vec_t tbl [8];
    int   ntbl;

    initial begin
        logic [7:0] model_pc;
        int         cnt_a, cnt_b, cnt_c;

        reset = 1'b0; run = 1'b0; env_init = 1'b1;
        cond_ovr_en = 1'b0; cond_ovr_val = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 32'h0000_0030;

        tbl[0] = '{32'h02_05_03_C0, 1'b0, 4, 8'h01, 1, 3'd2, 8'h08, 0, 8'h00, 8'h00}; // ALU imm add
        tbl[1] = '{32'h40_00_00_10, 1'b1, 3, 8'h40, 0, 3'd0, 8'h00, 0, 8'h00, 8'h00}; // taken
        tbl[2] = '{32'h40_00_00_10, 1'b0, 3, 8'h01, 0, 3'd0, 8'h00, 0, 8'h00, 8'h00}; // not taken
        tbl[3] = '{32'h03_00_10_A0, 1'b0, 3 + MW, 8'h01, 1, 3'd3, 8'h5A, 0, 8'h00, 8'h00}; // load
        tbl[4] = '{32'h00_77_20_E1, 1'b0, 3, 8'h01, 0, 3'd0, 8'h00, 1, 8'h20, 8'h77}; // store
        tbl[5] = '{32'h00_00_00_30, 1'b0, 2, 8'h01, 0, 3'd0, 8'h00, 0, 8'h00, 8'h00}; // NOP
        tbl[6] = '{32'h05_02_01_04, 1'b0, 4, 8'h01, 1, 3'd5, 8'h31, 0, 8'h00, 8'h00}; // reg xor
        ntbl = 7;
`ifndef LIMB_SEQ_TRAP_EN
        tbl[7] = '{32'h00_00_00_22, 1'b0, 3, 8'h01, 0, 3'd0, 8'h00, 0, 8'h00, 8'h00}; // MEM op 2 as NOP
        ntbl = 8;
`endif

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_rom_addr", rom_addr, 8'h00);
        chk("rst_halted", halted, 0);
        chk("rst_retire", retire, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_rf_wdata", rf_wdata, 8'h00);

        // table-driven single instructions from reset
        run = 1'b1;
        cond_ovr_en = 1'b1;
        for (int v = 0; v < ntbl; v++) begin
            rom[0] = tbl[v].word;
            cond_ovr_val = tbl[v].cond_v;
            do_reset();
            run_instr();
            $display("vec %0d: word=%08h lat=%0d npc=%02h rf_we=%0d ram_we=%0d",
                     v, tbl[v].word, act_lat, rom_addr, act_nrf, act_nram);
            chk("tbl_lat", act_lat, tbl[v].lat);
            chk("tbl_npc", rom_addr, tbl[v].npc);
            chk("tbl_nrf", act_nrf, tbl[v].nrf);
            chk("tbl_nram", act_nram, tbl[v].nram);
            if (tbl[v].nrf != 0) begin
                chk("tbl_rf_dst", act_dst, tbl[v].dst);
                chk("tbl_rf_wdata", act_wd, tbl[v].wd);
            end
            if (tbl[v].nram != 0) begin
                chk("tbl_ram_addr", act_ra, tbl[v].ra);
                chk("tbl_ram_wdata", act_rd, tbl[v].rd);
            end
        end
        cond_ovr_en = 1'b0;

        // PC wrap: 255 NOPs from 0 reach 0xFF, one more wraps to 0
        for (int i = 0; i < 256; i++) rom[i] = 32'h0000_0030;
        do_reset();
        for (int i = 0; i < 255; i++) run_instr();
        chk("wrap_pc_ff", rom_addr, 8'hFF);
        run_instr();
        chk("wrap_lat", act_lat, 2);
        chk("wrap_pc_00", rom_addr, 8'h00);
        $display("pc wrap: rom_addr=%02h", rom_addr);

        // run dropped during EXECUTE: instruction completes, then FSM idles in FETCH
        rom[0] = 32'h02_05_03_C0;
        do_reset();
        repeat (2) @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        chk("runlow_rf_we", rf_we, 1);
        chk("runlow_retire", retire, 1);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cnt_a += int'(retire);
            cnt_b += int'(rf_we) + int'(ram_we);
        end
        chk("runlow_idle_retire", cnt_a, 0);
        chk("runlow_idle_strobes", cnt_b, 0);
        chk("runlow_pc", rom_addr, 8'h01);
        $display("run low: pc=%02h retires_while_idle=%0d", rom_addr, cnt_a);
        run = 1'b1;

        // HALT
        rom[0] = 32'h0000_0031;
        do_reset();
        run_instr();
        chk("halt_lat", act_lat, 2);
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int i = 0; i < 6; i++) begin
            cnt_a += int'(halted);
            cnt_b += int'(retire);
            cnt_c += int'(rom_addr != 8'h00);
            @(negedge clk);
        end
        chk("halt_cycles", cnt_a, 6);
        chk("halt_retire", cnt_b, 0);
        chk("halt_pc_moved", cnt_c, 0);
        $display("halt: halted_cycles=%0d", cnt_a);

        // reset asserted mid-WRITEBACK
        rom[0] = 32'h02_05_03_C0;
        do_reset();
        repeat (3) @(negedge clk);
        chk("midrst_wb_active", rf_we, 1);
        #1 reset = 1'b0;
        #1;
        chk("midrst_rf_we", rf_we, 0);
        chk("midrst_retire", retire, 0);
        chk("midrst_rom_addr", rom_addr, 8'h00);
        $display("reset mid-writeback: rf_we=%0b rom_addr=%02h", rf_we, rom_addr);

        // random program against the instruction-level model
        for (int i = 0; i < 256; i++) begin
            logic [1:0] cls;
            logic [3:0] op;
            cls = 2'($urandom_range(0, 3));
            case (cls)
`ifdef LIMB_SEQ_TRAP_EN
                2'b00, 2'b01: op = 4'($urandom_range(0, 7));
                2'b10:        op = 4'($urandom_range(0, 1));
`else
                2'b00, 2'b01: op = 4'($urandom_range(0, 15));
                2'b10:        op = ($urandom_range(0, 3) == 0) ? 4'd5 : 4'($urandom_range(0, 1));
`endif
                default:      op = 4'd0;
            endcase
            rom[i] = {8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), cls, op};
        end
        for (int i = 0; i < 8; i++) m_regs[i] = reg_init(i);
        for (int i = 0; i < 256; i++) m_ram[i] = ram_init(i);
        do_reset();
        model_pc = 8'h00;
        for (int n = 0; n < 300; n++) begin
            chk("rnd_pc", rom_addr, model_pc);
            model_step(model_pc);
            run_instr();
            $display("rnd %0d: pc=%02h ir=%08h lat=%0d", n, model_pc, rom[model_pc], act_lat);
            chk("rnd_lat", act_lat, exp_lat);
            chk("rnd_nrf", act_nrf, exp_nrf);
            chk("rnd_nram", act_nram, exp_nram);
            chk("rnd_halt", act_halt, exp_halt);
            if (exp_nrf != 0) begin
                chk("rnd_rf_dst", act_dst, exp_dst);
                chk("rnd_rf_wdata", act_wd, exp_wd);
            end
            if (exp_nram != 0) begin
                chk("rnd_ram_addr", act_ra, exp_ra);
                chk("rnd_ram_wdata", act_rd, exp_rd);
            end
            model_pc = exp_npc;
            if (exp_halt) break;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
